// File: rtl/bus_arbiter_pkg.sv
// Shared coherence-bus types: request classes, arbiter states and the bus
// controller state encoding.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    EVICT = 2'd0,
    RX    = 2'd1,
    R     = 2'd2,
    INV   = 2'd3
  } bus_req_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OFFER = 2'd1,
    ARB_BUSY  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_ARB   = 2'd1,
    BUS_XFER  = 2'd2,
    BUS_SNOOP = 2'd3
  } bus_state_t;

endpackage

// File: rtl/rr_picker.sv
// Rotating priority encoder: first set bit of mask, searching upward from
// ptr+1 and wrapping modulo CPUS.
module rr_picker #(
  parameter int CPUS = 4,
  parameter int IW   = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic [CPUS-1:0] mask,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   id
);

  localparam logic [IW:0] CPUS_W = (IW+1)'(CPUS);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  always_comb begin
    valid = 1'b0;
    id    = '0;
    sum   = '0;
    idx   = '0;
    for (int i = 1; i <= CPUS; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= CPUS_W) sum = sum - CPUS_W;
      idx = sum[IW-1:0];
      if (!valid && mask[idx]) begin
        valid = 1'b1;
        id    = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Coherence-bus arbiter: class-priority round-robin with age-based starvation
// promotion, offer/accept handshake and abort.
//
// state     | meaning
// ARB_IDLE  | no grant; arbitrate pending requests
// ARB_OFFER | grant offered, waiting for grant_ready
// ARB_BUSY  | grant accepted, waiting for txn_done
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int CPUS      = 4,
  parameter int AGE_LIMIT = 8,
  localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1,
  localparam int AW = $clog2(AGE_LIMIT + 1)
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [CPUS-1:0] dREN,
  input  logic [CPUS-1:0] dWEN,
  input  logic [CPUS-1:0] ccwrite,
  input  logic            grant_ready,
  input  logic            txn_done,
  input  logic            abort_bus,
  output logic            grant_valid,
  output logic [IW-1:0]   grant_cpu,
  output logic [CPUS-1:0] grant_onehot,
  output bus_req_t        grant_type
);

  localparam logic [AW-1:0] AGE_MAX = AW'(AGE_LIMIT);

  arb_state_t      state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [AW-1:0]   age [CPUS];
  logic [CPUS-1:0] req_any, m_evict, m_rx, m_r, m_inv, m_starved;
  bus_req_t        cls [CPUS];
  logic            v_st, v_ev, v_rx, v_r, v_inv;
  logic [IW-1:0]   id_st, id_ev, id_rx, id_r, id_inv;
  logic [IW-1:0]   win_cpu;
  bus_req_t        win_type;

  always_comb begin
    req_any   = dWEN | dREN | ccwrite;
    m_evict   = dWEN;
    m_rx      = ~dWEN & dREN & ccwrite;
    m_r       = ~dWEN & dREN & ~ccwrite;
    m_inv     = ~dWEN & ~dREN & ccwrite;
    m_starved = '0;
    for (int i = 0; i < CPUS; i++) begin
      m_starved[i] = req_any[i] && (age[i] == AGE_MAX);
      cls[i] = dWEN[i] ? EVICT : (dREN[i] ? (ccwrite[i] ? RX : R) : INV);
    end
  end

  rr_picker #(.CPUS(CPUS), .IW(IW)) u_pick_st  (.mask(m_starved), .ptr(rr_ptr), .valid(v_st),  .id(id_st));
  rr_picker #(.CPUS(CPUS), .IW(IW)) u_pick_ev  (.mask(m_evict),   .ptr(rr_ptr), .valid(v_ev),  .id(id_ev));
  rr_picker #(.CPUS(CPUS), .IW(IW)) u_pick_rx  (.mask(m_rx),      .ptr(rr_ptr), .valid(v_rx),  .id(id_rx));
  rr_picker #(.CPUS(CPUS), .IW(IW)) u_pick_r   (.mask(m_r),       .ptr(rr_ptr), .valid(v_r),   .id(id_r));
  rr_picker #(.CPUS(CPUS), .IW(IW)) u_pick_inv (.mask(m_inv),     .ptr(rr_ptr), .valid(v_inv), .id(id_inv));

  // A starved requester beats every class; its own class is what gets granted.
  always_comb begin
    win_cpu  = id_inv;
    win_type = INV;
    if (v_st) begin
      win_cpu  = id_st;
      win_type = cls[id_st];
    end else if (v_ev) begin
      win_cpu  = id_ev;
      win_type = EVICT;
    end else if (v_rx) begin
      win_cpu  = id_rx;
      win_type = RX;
    end else if (v_r) begin
      win_cpu  = id_r;
      win_type = R;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (!abort_bus && (|req_any)) state_nxt = ARB_OFFER;
      end
      ARB_OFFER: begin
        if (abort_bus)                 state_nxt = ARB_IDLE;
        else if (grant_ready)          state_nxt = ARB_BUSY;
        else if (!req_any[grant_cpu])  state_nxt = ARB_IDLE;
      end
      ARB_BUSY: begin
        if (abort_bus || txn_done) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr     <= IW'(CPUS - 1);
      grant_cpu  <= '0;
      grant_type <= EVICT;
      for (int i = 0; i < CPUS; i++) age[i] <= '0;
    end else begin
      if (state == ARB_IDLE && state_nxt == ARB_OFFER) begin
        grant_cpu  <= win_cpu;
        grant_type <= win_type;
      end
      if (state == ARB_OFFER && state_nxt == ARB_BUSY) begin
        for (int i = 0; i < CPUS; i++) begin
          if (grant_cpu == IW'(i))                    age[i] <= '0;
          else if (req_any[i] && (age[i] != AGE_MAX)) age[i] <= age[i] + 1'b1;
        end
      end
      if (state == ARB_BUSY && !abort_bus && txn_done) rr_ptr <= grant_cpu;
    end
  end

  always_comb begin
    grant_valid  = (state != ARB_IDLE);
    grant_onehot = '0;
    if (grant_valid) grant_onehot[grant_cpu] = 1'b1;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: round-robin order, class priority,
// starvation promotion, offer withdrawal, abort and async reset.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int CPUS      = 4;
  localparam int AGE_LIMIT = 8;

  logic            CLK = 1'b0;
  logic            nRST = 1'b0;
  logic [CPUS-1:0] dREN = '0, dWEN = '0, ccwrite = '0;
  logic            grant_ready = 1'b0, txn_done = 1'b0, abort_bus = 1'b0;
  logic            grant_valid;
  logic [1:0]      grant_cpu;
  logic [CPUS-1:0] grant_onehot;
  bus_req_t        grant_type;

  int vectors = 0;
  int miscompares = 0;

  bus_arbiter #(.CPUS(CPUS), .AGE_LIMIT(AGE_LIMIT)) dut (
    .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .ccwrite(ccwrite),
    .grant_ready(grant_ready), .txn_done(txn_done), .abort_bus(abort_bus),
    .grant_valid(grant_valid), .grant_cpu(grant_cpu),
    .grant_onehot(grant_onehot), .grant_type(grant_type)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_grant(input string tag, input int c, input bus_req_t t);
    int n = 0;
    while (!grant_valid && n < 8) begin
      tick();
      n++;
    end
    chk({tag, ".valid"},  32'(grant_valid), 32'd1);
    chk({tag, ".cpu"},    32'(grant_cpu), 32'(c));
    chk({tag, ".type"},   32'(grant_type), 32'(t));
    chk({tag, ".onehot"}, 32'(grant_onehot), 32'd1 << c);
  endtask

  task automatic do_grant(input string tag, input int c, input bus_req_t t, input bit drop);
    wait_grant(tag, c, t);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    chk({tag, ".busy_valid"}, 32'(grant_valid), 32'd1);
    chk({tag, ".busy_cpu"},   32'(grant_cpu), 32'(c));
    txn_done = 1'b1;
    if (drop) begin
      dREN[c] = 1'b0;
      dWEN[c] = 1'b0;
      ccwrite[c] = 1'b0;
    end
    tick();
    txn_done = 1'b0;
    chk({tag, ".released"}, 32'(grant_valid), 32'd0);
  endtask

  task automatic pulse_reset();
    nRST = 1'b0;
    tick();
    @(negedge CLK);
    nRST = 1'b1;
    tick();
  endtask

  initial begin
    #12;
    chk("rst.valid",  32'(grant_valid), 32'd0);
    chk("rst.cpu",    32'(grant_cpu), 32'd0);
    chk("rst.onehot", 32'(grant_onehot), 32'd0);
    chk("rst.type",   32'(grant_type), 32'(EVICT));
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    // handshake strobes while idle must do nothing
    grant_ready = 1'b1;
    txn_done = 1'b1;
    tick();
    grant_ready = 1'b0;
    txn_done = 1'b0;
    chk("idle_strobe.valid", 32'(grant_valid), 32'd0);

    // all CPUs reading: plain round-robin from CPU0
    dREN = '1;
    for (int i = 0; i < 5; i++) do_grant($sformatf("rr%0d", i), i % 4, R, 1'b0);
    dREN = '0;
    tick();

    // eviction beats read; read granted next; one-cycle latency from idle
    dREN[2] = 1'b1;
    dWEN[3] = 1'b1;
    tick();
    chk("prio.latency", 32'(grant_valid), 32'd1);
    do_grant("prio_ev", 3, EVICT, 1'b1);
    do_grant("prio_r", 2, R, 1'b1);

    // starvation: CPU1 read loses 8 times to CPU0 eviction, then wins; repeats
    pulse_reset();
    dWEN[0] = 1'b1;
    dREN[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < AGE_LIMIT; j++) do_grant($sformatf("age%0d_ev%0d", k, j), 0, EVICT, 1'b0);
      do_grant($sformatf("age%0d_starved", k), 1, R, 1'b0);
    end
    do_grant("age_after", 0, EVICT, 1'b0);
    dWEN = '0;
    dREN = '0;

    // offer withdrawn when the requester's class goes to none
    pulse_reset();
    ccwrite[2] = 1'b1;
    tick();
    wait_grant("inv_offer", 2, INV);
    ccwrite[2] = 1'b0;
    dREN[0] = 1'b1;
    dREN[3] = 1'b1;
    tick();
    chk("inv_withdraw.valid",  32'(grant_valid), 32'd0);
    chk("inv_withdraw.onehot", 32'(grant_onehot), 32'd0);
    do_grant("inv_next0", 0, R, 1'b1);
    do_grant("inv_next3", 3, R, 1'b1);

    // abort while busy overrides txn_done and keeps rr_ptr (3)
    dREN[1] = 1'b1;
    dREN[2] = 1'b1;
    wait_grant("abort_offer", 1, R);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    chk("abort_busy.valid", 32'(grant_valid), 32'd1);
    abort_bus = 1'b1;
    txn_done = 1'b1;
    tick();
    abort_bus = 1'b0;
    txn_done = 1'b0;
    chk("abort.valid",  32'(grant_valid), 32'd0);
    chk("abort.onehot", 32'(grant_onehot), 32'd0);
    tick();
    chk("abort_rearb.valid", 32'(grant_valid), 32'd1);
    chk("abort_rearb.cpu",   32'(grant_cpu), 32'd1);
    do_grant("abort_g1", 1, R, 1'b1);
    do_grant("abort_g2", 2, R, 1'b1);

    // async reset during an offer (rr_ptr=2 -> CPU3 offered)
    dREN = '1;
    tick();
    wait_grant("rst_offer", 3, R);
    #2;
    nRST = 1'b0;
    #1;
    chk("async_rst.valid",  32'(grant_valid), 32'd0);
    chk("async_rst.cpu",    32'(grant_cpu), 32'd0);
    chk("async_rst.onehot", 32'(grant_onehot), 32'd0);
    chk("async_rst.type",   32'(grant_type), 32'(EVICT));
    @(negedge CLK);
    nRST = 1'b1;
    wait_grant("post_rst", 0, R);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter CPUS, default 4, number of L1 requesters sharing the coherence bus.
REQ-002 Parameter AGE_LIMIT, default 8, number of lost grants after which a waiting CPU is promoted.
REQ-003 CLK  input  1  single clock; all state changes on posedge CLK.
REQ-004 nRST  input  1  asynchronous, active-low reset.
REQ-005 dREN  input  CPUS  per-CPU read request.
REQ-006 dWEN  input  CPUS  per-CPU eviction (writeback) request.
REQ-007 ccwrite  input  CPUS  per-CPU write intent (RX with dREN, INV alone).
REQ-008 grant_ready  input  1  bus controller accepts the offered grant this cycle.
REQ-009 txn_done  input  1  bus controller finished the accepted transaction.
REQ-010 abort_bus  input  1  exception abort; forces the arbiter to idle.
REQ-011 grant_valid  output  1  a grant is offered or held.
REQ-012 grant_cpu  output  $clog2(CPUS)  granted CPU id.
REQ-013 grant_onehot  output  CPUS  one-hot form of grant_cpu; all zero when grant_valid=0.
REQ-014 grant_type  output  bus_req_t  class of granted request.

Function
REQ-015 Per-CPU request class SHALL be: EVICT if dWEN; else RX if dREN&ccwrite; else R if dREN; else INV if ccwrite; else none.
REQ-016 Class priority SHALL be EVICT > RX > R > INV.
REQ-017 Within a class, selection SHALL be round-robin starting at rr_ptr+1 mod CPUS.
REQ-018 Any requesting CPU with age == AGE_LIMIT SHALL win over class priority; ties among starved CPUs SHALL resolve round-robin from rr_ptr+1.
REQ-019 States: ARB_IDLE, ARB_OFFER, ARB_BUSY.
REQ-020 ARB_IDLE: if any request exists, register winner, cpu and class, and go to ARB_OFFER; else stay.
REQ-021 Latency: a request present in ARB_IDLE at edge N SHALL give grant_valid=1 after edge N+1.
REQ-022 ARB_OFFER: grant_valid=1, and grant_cpu/grant_type SHALL hold stable until grant_ready.
REQ-023 ARB_OFFER with grant_ready=1 SHALL go to ARB_BUSY.
REQ-024 ARB_OFFER with the granted CPU's class now none and grant_ready=0 SHALL return to ARB_IDLE, withdraw the grant, and leave rr_ptr and ages unchanged.
REQ-025 ARB_BUSY: grant_valid=1 with outputs held; txn_done SHALL go to ARB_IDLE and set rr_ptr <= grant_cpu.
REQ-026 On the ARB_OFFER->ARB_BUSY transition, the granted CPU's age SHALL clear to 0.
REQ-027 On that same transition, every other CPU with a non-none class SHALL have its age incremented, saturating at AGE_LIMIT.
REQ-028 Age width SHALL be $clog2(AGE_LIMIT+1) bits.
REQ-029 txn_done arriving together with new requests SHALL return to ARB_IDLE, leaving one dead cycle before the next grant.
REQ-030 abort_bus SHALL force ARB_IDLE from any state next cycle with grant_valid=0; rr_ptr and ages SHALL be unchanged; abort_bus SHALL override grant_ready and txn_done.
REQ-031 grant_ready or txn_done asserted in an unexpected state SHALL be ignored.

Reset
REQ-032 Reset SHALL set: state=ARB_IDLE, rr_ptr=CPUS-1 (CPU0 first), all ages=0.
REQ-033 Reset SHALL set all outputs to 0, i.e. grant_valid=0, grant_cpu=0, grant_onehot=0, grant_type=EVICT encoding 0.
REQ-034 Reset mid-transaction SHALL discard the grant without any handshake.

Structure
REQ-035 bus_req_t (EVICT=0, RX=1, R=2, INV=3) and arb_state_t SHALL live in the shared coherence package alongside bus_state_t.
REQ-036 One sub-module, rr_picker (CPUS-wide rotating priority encoder: mask, ptr -> valid, id), SHALL be instantiated once per class plus once for the starved set.

Verification
REQ-037 CPUS=4; dREN=4'b1111 continuously; each grant gets ready and done after 1 cycle -> grants in order 0,1,2,3,0.
REQ-038 dREN[2]=1 and dWEN[3]=1 in the same cycle -> CPU3 granted with EVICT; CPU2 granted R next.
REQ-039 dWEN[0]=1 held continuously with dREN[1]=1 -> CPU1 age reaches 8 after 8 CPU0 grants; the 9th grant goes to CPU1 with type R, and CPU1's age returns to 0.
REQ-040 Offer to CPU2 (INV), then ccwrite[2] drops before grant_ready -> grant_valid falls next cycle, rr_ptr is unchanged, and CPU0 is granted next.
REQ-041 abort_bus pulsed in ARB_BUSY -> grant_valid=0 next cycle, rr_ptr is unchanged, and pending requests are re-arbitrated one cycle later.
REQ-042 nRST asserted in ARB_OFFER -> all outputs are 0 immediately (asynchronously); after release, CPU0 wins when all CPUs request.
